// File: rtl/q_ram_loader_pkg.sv
// Shared constants and types for the matrix write-side loader.
// Default widths match the four-RAM matrix bank (N=4, 16-bit elements, 16 addresses).
package q_ram_loader_pkg;

    localparam int DEF_WORD_LEN   = 16;
    localparam int DEF_MATRIX_DIM = 4;
    localparam int DEF_ADDR_BITS  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } load_state_t;

endpackage

// File: rtl/q_ram_loader_if.sv
// Element-pair stream from the host/test-data source into the loader.
// The master drives pairs; the slave (loader) answers with in_ready.
interface q_ram_loader_if
    import q_ram_loader_pkg::*;
#(
    parameter int WORD_LEN = DEF_WORD_LEN
);
    logic                in_valid;
    logic                in_ready;
    logic [WORD_LEN-1:0] in_m1;
    logic [WORD_LEN-1:0] in_m2;

    modport master (
        output in_valid,
        output in_m1,
        output in_m2,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_m1,
        input  in_m2,
        output in_ready
    );

endinterface

// File: rtl/q_ram_loader_dim_counter.sv
// Mod-N counter with synchronous clear and enable.
// wrap is high in the enabled cycle in which the count rolls from N-1 back to 0.
module q_ram_loader_dim_counter #(
    parameter int N     = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/q_ram_loader.sv
// Write-side sequencer: accepts element pairs and issues row-major writes
// to the M1/M2 matrix RAM bank, flagging when a full N x N pair is resident.
module q_ram_loader
    import q_ram_loader_pkg::*;
#(
    parameter int WORD_LEN   = DEF_WORD_LEN,
    parameter int MATRIX_DIM = DEF_MATRIX_DIM,
    parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    q_ram_loader_if.slave        src,
    output logic                 we,
    output logic [WORD_LEN-1:0]  data_m1,
    output logic [WORD_LEN-1:0]  data_m2,
    output logic [ADDR_BITS-1:0] Dir_M1,
    output logic [ADDR_BITS-1:0] Dir_M2,
    output logic                 busy,
    output logic                 done,
    output logic                 loaded
);

    localparam logic [ADDR_BITS-1:0] DIM  = ADDR_BITS'(MATRIX_DIM);
    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(MATRIX_DIM - 1);

    load_state_t          state;
    load_state_t          next_state;
    logic                 cnt_clr;
    logic                 transfer;
    logic                 last_elem;
    logic [ADDR_BITS-1:0] row;
    logic [ADDR_BITS-1:0] col;
    logic                 col_wrap;
    logic                 row_wrap;
    logic [ADDR_BITS-1:0] elem_addr;

    assign src.in_ready = (state == ST_LOAD) && !abort;
    assign transfer     = src.in_valid && src.in_ready;
    assign last_elem    = (row == LAST) && (col == LAST);
    assign elem_addr    = row * DIM + col;
    assign busy         = (state == ST_LOAD);

    q_ram_loader_dim_counter #(
        .N     (MATRIX_DIM),
        .WIDTH (ADDR_BITS)
    ) u_col (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (transfer),
        .count (col),
        .wrap  (col_wrap)
    );

    q_ram_loader_dim_counter #(
        .N     (MATRIX_DIM),
        .WIDTH (ADDR_BITS)
    ) u_row (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (col_wrap),
        .count (row),
        .wrap  (row_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start outranks abort in IDLE because abort is only examined in LOAD
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_LOAD;
                    cnt_clr    = 1'b1;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    next_state = ST_IDLE;
                end else if (transfer && last_elem) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we      <= 1'b0;
            done    <= 1'b0;
            loaded  <= 1'b0;
            data_m1 <= '0;
            data_m2 <= '0;
            Dir_M1  <= '0;
            Dir_M2  <= '0;
        end else begin
            we   <= transfer;
            done <= transfer && last_elem;
            if (transfer) begin
                data_m1 <= src.in_m1;
                data_m2 <= src.in_m2;
                Dir_M1  <= elem_addr;
                Dir_M2  <= elem_addr;
            end
            if (state == ST_IDLE && start) begin
                loaded <= 1'b0;
            end else if (transfer && last_elem) begin
                loaded <= 1'b1;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = row_wrap;

endmodule

// File: tb/tb_q_ram_loader.sv
// Randomized bench for q_ram_loader against an element-index reference model.
// The model tracks accepted pairs by index; the expected address is that index.
module tb_q_ram_loader;
    import q_ram_loader_pkg::*;

    localparam int WL       = DEF_WORD_LEN;
    localparam int AB       = DEF_ADDR_BITS;
    localparam int NELEM    = DEF_MATRIX_DIM * DEF_MATRIX_DIM;
    localparam int LAST_IDX = NELEM - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          we;
    logic [WL-1:0] data_m1;
    logic [WL-1:0] data_m2;
    logic [AB-1:0] Dir_M1;
    logic [AB-1:0] Dir_M2;
    logic          busy;
    logic          done;
    logic          loaded;

    int tests_run    = 0;
    int tests_failed = 0;

    bit            m_active;
    int            m_idx;
    logic          e_we;
    logic          e_done;
    logic          e_loaded;
    logic [WL-1:0] e_d1;
    logic [WL-1:0] e_d2;
    logic [AB-1:0] e_dir;
    logic [WL-1:0] pat1 [NELEM];
    logic [WL-1:0] pat2 [NELEM];

    q_ram_loader_if #(.WORD_LEN(WL)) bus ();

    q_ram_loader dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .src     (bus.slave),
        .we      (we),
        .data_m1 (data_m1),
        .data_m2 (data_m2),
        .Dir_M1  (Dir_M1),
        .Dir_M2  (Dir_M2),
        .busy    (busy),
        .done    (done),
        .loaded  (loaded)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("we",      32'(we),      32'(e_we));
        checkOutput("done",    32'(done),    32'(e_done));
        checkOutput("loaded",  32'(loaded),  32'(e_loaded));
        checkOutput("busy",    32'(busy),    32'(m_active));
        checkOutput("data_m1", 32'(data_m1), 32'(e_d1));
        checkOutput("data_m2", 32'(data_m2), 32'(e_d2));
        checkOutput("Dir_M1",  32'(Dir_M1),  32'(e_dir));
        checkOutput("Dir_M2",  32'(Dir_M2),  32'(e_dir));
    endtask

    task automatic modelReset();
        m_active = 1'b0;
        m_idx    = 0;
        e_we     = 1'b0;
        e_done   = 1'b0;
        e_loaded = 1'b0;
        e_d1     = '0;
        e_d2     = '0;
        e_dir    = '0;
    endtask

    // One clock of stimulus: drive at negedge, step the model at posedge, check after it
    task automatic applyStimulus(input logic st, input logic ab, input logic v,
                                 input logic [WL-1:0] m1, input logic [WL-1:0] m2);
        logic acc;
        @(negedge clk);
        start        = st;
        abort        = ab;
        bus.in_valid = v;
        bus.in_m1    = m1;
        bus.in_m2    = m2;
        #1;
        checkOutput("in_ready", 32'(bus.in_ready), 32'(m_active && !ab));
        @(posedge clk);
        acc    = m_active && !ab && v;
        e_we   = acc;
        e_done = acc && (m_idx == LAST_IDX);
        if (acc) begin
            e_d1  = m1;
            e_d2  = m2;
            e_dir = AB'(m_idx);
        end
        if (!m_active) begin
            if (st) begin
                m_active = 1'b1;
                m_idx    = 0;
                e_loaded = 1'b0;
            end
        end else if (ab) begin
            m_active = 1'b0;
        end else if (acc) begin
            if (m_idx == LAST_IDX) begin
                m_active = 1'b0;
                e_loaded = 1'b1;
            end
            m_idx++;
        end
        #1;
        checkAll();
    endtask

    task automatic idleCycles(input int n, input logic v, input logic ab);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, ab, v, WL'($urandom), WL'($urandom));
        end
    endtask

    // vmode: 0 = valid held high, 1 = toggling, 2 = random; pulses start again at restart_at
    task automatic runLoad(input int stop_idx, input int vmode, input int restart_at,
                           input logic start_abort, input bit use_k);
        int   cyc;
        bit   restarted;
        logic v;
        for (int k = 0; k < NELEM; k++) begin
            pat1[k] = use_k ? WL'(k)         : WL'($urandom);
            pat2[k] = use_k ? WL'(16'h100 + k) : WL'($urandom);
        end
        applyStimulus(1'b1, start_abort, 1'b0, '0, '0);
        cyc       = 0;
        restarted = 1'b0;
        while (m_active && m_idx < stop_idx && cyc < 500) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (restart_at >= 0 && m_idx == restart_at && !restarted) begin
                restarted = 1'b1;
                applyStimulus(1'b1, 1'b0, v, pat1[m_idx], pat2[m_idx]);
            end else begin
                applyStimulus(1'b0, 1'b0, v, pat1[m_idx], pat2[m_idx]);
            end
            cyc++;
        end
        checkOutput("load_bounded", 32'(cyc < 500), 32'd1);
    endtask

    task automatic doReset();
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_we",     32'(we),           32'd0);
        checkOutput("rst_busy",   32'(busy),         32'd0);
        checkOutput("rst_done",   32'(done),         32'd0);
        checkOutput("rst_loaded", 32'(loaded),       32'd0);
        checkOutput("rst_data",   32'({data_m1, data_m2}), 32'd0);
        checkOutput("rst_dir",    32'({Dir_M1, Dir_M2}),   32'd0);
        checkOutput("rst_ready",  32'(bus.in_ready), 32'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_m1    = '0;
        bus.in_m2    = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAll();

        // idle with valid high: nothing accepted
        idleCycles(5, 1'b1, 1'b0);
        idleCycles(2, 1'b1, 1'b1);

        // back-to-back load with k / 0x100+k data
        runLoad(NELEM, 0, -1, 1'b0, 1'b1);
        idleCycles(2, 1'b0, 1'b0);

        // toggling valid, start and abort together in IDLE
        runLoad(NELEM, 1, -1, 1'b1, 1'b0);
        idleCycles(2, 1'b1, 1'b0);

        // abort after 6 transfers, then a fresh load
        runLoad(6, 2, -1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, pat1[m_idx], pat2[m_idx]);
        idleCycles(2, 1'b1, 1'b0);
        runLoad(NELEM, 2, -1, 1'b0, 1'b0);
        idleCycles(1, 1'b0, 1'b0);

        // reset mid-load at transfer 10, then reload
        runLoad(10, 0, -1, 1'b0, 1'b0);
        doReset();
        idleCycles(1, 1'b1, 1'b0);
        runLoad(NELEM, 2, -1, 1'b0, 1'b0);
        idleCycles(1, 1'b0, 1'b0);

        // start re-pulsed at transfer 8 is ignored
        runLoad(NELEM, 0, 8, 1'b0, 1'b0);
        idleCycles(3, 1'b1, 1'b0);

        // a few extra random loads
        for (int r = 0; r < 3; r++) begin
            runLoad(NELEM, 2, int'($urandom_range(0, 15)), 1'b0, 1'b0);
            idleCycles(int'($urandom_range(1, 3)), 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
